proc_instr_sequencer: RTL and testbench
=======================================

Name: proc_instr_sequencer

Overview:
- Sequences the 16-bit host processor from a small internal program RAM.
- Host loads instruction words through a write port, then pulses start.
- Block issues each instruction over the processor's execute/ready handshake, stops on HALT, end of program or handshake timeout, and reports status and an issued-instruction count.
- Sits between system control logic and the processor host, driving its opcode/operand/addr/execute inputs.

Parameters:
- PROG_DEPTH, 16, program RAM entries (power of two, 2..256).
- PTR_W, 4, log2(PROG_DEPTH).
- TIMEOUT, 64, max cycles allowed in ISSUE or RELEASE before error (2..65535).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- prog_we  input  1  program RAM write strobe; ignored unless state is IDLE, DONE or ERROR.
- prog_addr  input  PTR_W  program RAM write index.
- prog_data  input  43  instruction word {opcode[42:40], addr[39:32], operand_a[31:16], operand_b[15:0]}.
- run_len  input  PTR_W+1  instructions to run; sampled on start.
- start  input  1  begin run; honoured in IDLE, DONE or ERROR only.
- proc_ready  input  1  processor ready.
- proc_halt  input  1  processor halted.
- opcode  output  3  to processor.
- addr  output  8  to processor.
- operand_a  output  16  to processor.
- operand_b  output  16  to processor.
- execute  output  1  to processor.
- busy  output  1  run in progress.
- done  output  1  run ended normally (sticky).
- error  output  1  timeout or halt at start (sticky).
- issued_count  output  PTR_W+1  instructions accepted this run.

Behaviour:
- Reset: all outputs 0; state IDLE; pointer 0; program RAM contents not reset.
- All outputs are registered. The program RAM read is combinational from the pointer and is registered into the operand outputs in FETCH.
- States: IDLE, FETCH, ISSUE, RELEASE, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - If run_len == 0 → DONE.
  - Else if proc_halt == 1 → ERROR.
  - Otherwise latch run_len, ptr = 0, clear done/error/issued_count, busy = 1, go FETCH.
  - run_len is clamped to PROG_DEPTH.
- FETCH (1 cycle): load opcode/addr/operands from RAM[ptr] → ISSUE.
- ISSUE:
  - execute = 1.
  - When proc_ready is sampled 0 after execute has been high for at least 1 cycle, the processor has accepted: execute → 0, issued_count++, go RELEASE.
- RELEASE: execute = 0.
  - If the issued opcode was 3'b111 (HALT) or proc_halt = 1 → DONE.
  - Else when proc_ready = 1: ptr++; if ptr+1 == latched run_len → DONE, else → FETCH.
- Timeout counter:
  - Cleared on entry to ISSUE and on entry to RELEASE.
  - Reaching TIMEOUT in either state → ERROR, execute = 0, busy = 0, error = 1.
- Entry to DONE: busy = 0, done = 1, execute = 0. Operand outputs hold their last values.
- JUMP (3'b110) is forwarded unchanged. The sequencer pointer always advances linearly; it does not track the processor pc.
- Simultaneous start and prog_we in IDLE: the write completes this cycle and the run reads the new data.
- prog_we while busy is dropped.
- start while busy is ignored.
- rst mid-run: immediate return to IDLE on the next edge with execute = 0.
- Handshake throughput: minimum 4 cycles per instruction (FETCH, ISSUE ≥ 2, RELEASE ≥ 1).

Test Plan:
- Load {ADD,0,0x0003,0x0004}, {SUB,0,0x0010,0x0001}; run_len = 2; start with a processor model → execute pulses twice, opcodes 000 then 001, issued_count = 2, done = 1, busy = 0.
- Program [LOAD, HALT, ADD]; run_len = 3 → ADD never issued, done = 1, issued_count = 2, execute stays 0 afterwards.
- Hold proc_ready = 1 permanently with TIMEOUT = 64 → error = 1 exactly 64 cycles after ISSUE entry, execute = 0, issued_count = 0.
- run_len = 0 with start → done = 1 next cycle, execute never asserted; run_len = 17 with PROG_DEPTH = 16 → exactly 16 issued.
- Assert rst during RELEASE of the 2nd of 4 instructions → next cycle: state IDLE, all outputs 0; a new start then reruns from entry 0.
- start while proc_halt = 1 → error = 1, no execute; prog_we while busy → RAM unchanged on the next run.

Source files
------------

// File: rtl/proc_instr_sequencer.sv
// rtl/proc_instr_sequencer.sv - program-RAM driven instruction sequencer for the 16-bit host processor
module proc_instr_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int PTR_W      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [PTR_W-1:0] prog_addr,
    input  logic [42:0]      prog_data,
    input  logic [PTR_W:0]   run_len,
    input  logic             start,
    input  logic             proc_ready,
    input  logic             proc_halt,
    output logic [2:0]       opcode,
    output logic [7:0]       addr,
    output logic [15:0]      operand_a,
    output logic [15:0]      operand_b,
    output logic             execute,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [PTR_W:0]   issued_count
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_RELEASE, S_DONE, S_ERROR} state_t;

    localparam logic [2:0]     OP_HALT  = 3'b111;
    localparam logic [PTR_W:0] DEPTH_L  = (PTR_W+1)'(PROG_DEPTH);
    localparam logic [PTR_W:0] ONE_L    = (PTR_W+1)'(1);
    localparam logic [15:0]    TMO_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   run_len_q, run_len_d;
    logic [15:0]      tmo_q, tmo_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [7:0]       addr_q, addr_d;
    logic [15:0]      opa_q, opa_d;
    logic [15:0]      opb_q, opb_d;
    logic             execute_q, execute_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    logic [42:0]      prog_mem [PROG_DEPTH];
    logic [42:0]      rd_word;
    logic [PTR_W:0]   ptr_inc;
    logic             idle_like;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    assign rd_word   = prog_mem[ptr_q];
    assign ptr_inc   = {1'b0, ptr_q} + ONE_L;

    // Program RAM has no reset; writes only land while no run is in flight.
    always_ff @(posedge clk) begin
        if (prog_we && idle_like) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        run_len_d = run_len_q;
        tmo_d     = tmo_q;
        opcode_d  = opcode_q;
        addr_d    = addr_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        execute_d = execute_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    // done and error are kept mutually exclusive: each reflects the last run outcome
                    if (run_len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 1'b0;
                    end else if (proc_halt) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        done_d  = 1'b0;
                    end else begin
                        state_d   = S_FETCH;
                        run_len_d = (run_len > DEPTH_L) ? DEPTH_L : run_len;
                        ptr_d     = '0;
                        done_d    = 1'b0;
                        error_d   = 1'b0;
                        cnt_d     = '0;
                        busy_d    = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                {opcode_d, addr_d, opa_d, opb_d} = rd_word;
                execute_d = 1'b1;
                tmo_d     = '0;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                // A nonzero counter means execute has already been seen by the processor for a cycle.
                if ((tmo_q != '0) && !proc_ready) begin
                    execute_d = 1'b0;
                    cnt_d     = cnt_q + ONE_L;
                    tmo_d     = '0;
                    state_d   = S_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    execute_d = 1'b0;
                    busy_d    = 1'b0;
                    error_d   = 1'b1;
                    done_d    = 1'b0;
                    state_d   = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_RELEASE: begin
                if ((opcode_q == OP_HALT) || proc_halt) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (proc_ready) begin
                    ptr_d = ptr_inc[PTR_W-1:0];
                    if (ptr_inc == run_len_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            run_len_q <= '0;
            tmo_q     <= '0;
            opcode_q  <= '0;
            addr_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            execute_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            run_len_q <= run_len_d;
            tmo_q     <= tmo_d;
            opcode_q  <= opcode_d;
            addr_q    <= addr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            execute_q <= execute_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cnt_q     <= cnt_d;
        end
    end

    assign opcode       = opcode_q;
    assign addr         = addr_q;
    assign operand_a    = opa_q;
    assign operand_b    = opb_q;
    assign execute      = execute_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign issued_count = cnt_q;

endmodule

// File: tb/tb_proc_instr_sequencer.sv
// tb/tb_proc_instr_sequencer.sv - self-checking bench for proc_instr_sequencer
module tb_proc_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [42:0] prog_data;
    logic [4:0]  run_len;
    logic        start;
    logic        proc_ready;
    logic        proc_halt;
    logic [2:0]  opcode;
    logic [7:0]  addr;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic        execute;
    logic        busy;
    logic        done;
    logic        error;
    logic [4:0]  issued_count;

    proc_instr_sequencer #(.PROG_DEPTH(16), .PTR_W(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .run_len(run_len), .start(start), .proc_ready(proc_ready), .proc_halt(proc_halt),
        .opcode(opcode), .addr(addr), .operand_a(operand_a), .operand_b(operand_b),
        .execute(execute), .busy(busy), .done(done), .error(error), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [42:0] mem_model [16];
    logic [42:0] exp_q [$];
    logic [2:0]  seen_ops [$];

    int proc_lat   = 0;
    bit proc_stuck = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [42:0] mk(input logic [2:0] op, input logic [7:0] a,
                                       input logic [15:0] x, input logic [15:0] y);
        return {op, a, x, y};
    endfunction

    // Expected issue list: linear walk from entry 0, clamped to depth, cut after a HALT.
    task automatic load_expect(input int rl, input bit halted);
        int lim;
        exp_q.delete();
        seen_ops.delete();
        lim = (rl > 16) ? 16 : rl;
        if (!halted) begin
            for (int i = 0; i < lim; i++) begin
                exp_q.push_back(mem_model[i]);
                if (mem_model[i][42:40] == 3'b111) break;
            end
        end
    endtask

    task automatic write_prog(input int idx, input logic [42:0] w);
        prog_we   = 1'b1;
        prog_addr = 4'(idx);
        prog_data = w;
        @(negedge clk);
        prog_we   = 1'b0;
        mem_model[idx] = w;
    endtask

    task automatic start_run(input int rl, input int lat, input bit halted);
        load_expect(rl, halted);
        proc_lat = lat;
        run_len  = 5'(rl);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, 64'(busy), 64'd0);
        check({name, "_all_issued"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Processor model: drops ready when it sees a new execute, raises it proc_lat cycles after execute falls.
    initial begin
        bit seen;
        int cnt;
        seen = 1'b0;
        cnt  = 0;
        proc_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (proc_stuck) begin
                proc_ready = 1'b1;
                seen = 1'b0;
            end else if (execute && !seen) begin
                proc_ready = 1'b0;
                seen = 1'b1;
                cnt = proc_lat;
            end else if (seen && !execute) begin
                if (cnt == 0) begin
                    proc_ready = 1'b1;
                    seen = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Per-cycle compare against the expected issue list and handshake bookkeeping.
    initial begin
        bit prev_exec, prev_busy, have_last;
        int rises, cyc, last_rise;
        logic [42:0] w;
        prev_exec = 1'b0; prev_busy = 1'b0; have_last = 1'b0;
        rises = 0; cyc = 0; last_rise = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) begin
                rises = 0;
                have_last = 1'b0;
            end
            if (execute && !prev_exec) begin
                rises++;
                if (have_last) check("issue_spacing_ge4", 64'(cyc - last_rise >= 4), 64'd1);
                have_last = 1'b1;
                last_rise = cyc;
                check("issue_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("issue_word", 64'({opcode, addr, operand_a, operand_b}), 64'(w));
                    seen_ops.push_back(opcode);
                end
            end
            if (execute) check("execute_implies_busy", 64'(busy), 64'd1);
            if (busy) begin
                check("count_track", 64'(issued_count), 64'(rises - int'(execute)));
                check("busy_not_done", 64'(done), 64'd0);
            end
            prev_exec = execute;
            prev_busy = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        run_len = '0; start = 1'b0; proc_halt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_opcode", 64'(opcode), 64'd0);
        check("rst_operands", 64'({addr, operand_a, operand_b}), 64'd0);
        check("rst_flags", 64'({execute, busy, done, error}), 64'd0);
        check("rst_count", 64'(issued_count), 64'd0);

        // zero-length run completes immediately
        start_run(0, 0, 1'b1);
        check("len0_done", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_exec", 64'(execute), 64'd0);

        // ADD then SUB
        write_prog(0, mk(3'b000, 8'h00, 16'h0003, 16'h0004));
        write_prog(1, mk(3'b001, 8'h00, 16'h0010, 16'h0001));
        start_run(2, 0, 1'b0);
        wait_idle("addsub");
        check("addsub_n_issued", 64'(seen_ops.size()), 64'd2);
        if (seen_ops.size() == 2) begin
            check("addsub_op0", 64'(seen_ops[0]), 64'd0);
            check("addsub_op1", 64'(seen_ops[1]), 64'd1);
        end
        check("addsub_count", 64'(issued_count), 64'd2);
        check("addsub_done", 64'({done, error}), 64'b10);
        check("addsub_hold_a", 64'(operand_a), 64'h10);

        // HALT stops the run before the trailing ADD
        write_prog(0, mk(3'b010, 8'h20, 16'h0005, 16'h0006));
        write_prog(1, mk(3'b111, 8'h00, 16'h0000, 16'h0000));
        write_prog(2, mk(3'b000, 8'h00, 16'h0001, 16'h0001));
        start_run(3, 1, 1'b0);
        wait_idle("halt");
        check("halt_count", 64'(issued_count), 64'd2);
        check("halt_done", 64'(done), 64'd1);
        repeat (5) @(negedge clk);
        check("halt_exec_low", 64'(execute), 64'd0);
        check("halt_last_op", 64'(opcode), 64'd7);

        // start while the processor is halted
        proc_halt = 1'b1;
        start_run(2, 0, 1'b1);
        proc_halt = 1'b0;
        check("halt_start_error", 64'(error), 64'd1);
        check("halt_start_flags", 64'({busy, execute}), 64'd0);

        // full program, run_len above depth, with a write attempted mid-run
        for (int i = 0; i < 16; i++)
            write_prog(i, mk(3'(i % 6), 8'(i), 16'(i * 3), 16'(16'hFFFF - 16'(i))));
        start_run(17, 0, 1'b0);
        repeat (6) @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = mk(3'b111, 8'hFF, 16'hDEAD, 16'hBEEF);
        @(negedge clk);
        prog_we = 1'b0;
        wait_idle("clamp");
        check("clamp_count", 64'(issued_count), 64'd16);
        check("clamp_n_issued", 64'(seen_ops.size()), 64'd16);

        start_run(2, 0, 1'b0);
        wait_idle("after_busy_we");
        if (seen_ops.size() > 0) check("busy_we_op0", 64'(seen_ops[0]), 64'd0);
        check("busy_we_hold", 64'({opcode, operand_a, operand_b}), 64'({3'd1, 16'd3, 16'hFFFE}));

        // reset in RELEASE of the 2nd of 4 instructions
        start_run(4, 3, 1'b0);
        n = 0;
        while (issued_count != 5'd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached", 64'(issued_count), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_flags", 64'({execute, busy, done, error}), 64'd0);
        check("rst_mid_outs", 64'({opcode, addr, operand_a, operand_b, issued_count}), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        start_run(4, 0, 1'b0);
        wait_idle("rerun");
        check("rerun_count", 64'(issued_count), 64'd4);
        if (seen_ops.size() > 0) check("rerun_op0", 64'(seen_ops[0]), 64'd0);

        // simultaneous write and start: new entry 0 is what runs
        mem_model[0] = mk(3'b101, 8'hAA, 16'h1234, 16'h5678);
        load_expect(1, 1'b0);
        proc_lat = 0;
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = mem_model[0];
        run_len = 5'd1; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        wait_idle("we_start");
        if (seen_ops.size() > 0) check("we_start_op", 64'(seen_ops[0]), 64'd5);
        check("we_start_count", 64'(issued_count), 64'd1);

        // processor never accepts: timeout 64 cycles after ISSUE entry
        proc_stuck = 1'b1;
        repeat (2) @(negedge clk);
        start_run(1, 0, 1'b0);
        n = 0;
        while (!execute && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tmo_exec_seen", 64'(execute), 64'd1);
        n = 0;
        while (!error && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", 64'(n), 64'd64);
        check("tmo_flags", 64'({error, busy, execute}), 64'b100);
        check("tmo_count", 64'(issued_count), 64'd0);
        proc_stuck = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
